fifo_out_arb: RTL and testbench



---
 rtl/fifo_out_arb.sv | 72 +++++++
 tb/tb_fifo_out_arb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_out_arb.sv
// fifo_out_arb: round-robin burst arbiter feeding one fifo_out; optional FIFO_ARB_CAP_RESERVE_EN grants only with BURST free slots
module fifo_out_arb #(
  parameter int OUTW  = 8,
  parameter int DEPTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ*OUTW-1:0]       in_TDATA,
  input  logic [NREQ-1:0]            in_TVALID,
  output logic [NREQ-1:0]            in_TREADY,
  output logic [OUTW-1:0]            data_in,
  output logic                       wr_en,
  input  logic [$clog2(DEPTH+1)-1:0] capacity,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = BURST > 1 ? $clog2(BURST) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IW-1:0] owner, last_owner, pick, idx;
  logic [BW-1:0] beat;
  logic found, grant_ok, xfer;
  // first valid requester after last_owner; descending scan so the nearest one wins
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_owner) + k) % NREQ);
      if (in_TVALID[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
`ifdef FIFO_ARB_CAP_RESERVE_EN
  assign grant_ok = capacity >= $bits(capacity)'(BURST);
`else
  assign grant_ok = 1'b1;
`endif
  assign xfer      = state == BUSY && in_TVALID[owner] && capacity != '0;
  assign in_TREADY = (state == BUSY && capacity != '0) ? NREQ'(1) << owner : '0;
  assign wr_en     = xfer;
  assign data_in   = xfer ? in_TDATA[owner*OUTW +: OUTW] : '0;
  assign grant_id  = owner;
  assign busy      = state == BUSY;
  // grant in IDLE, count beats in BUSY, release after the last beat of the burst
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      last_owner <= IW'(NREQ - 1);
      beat <= '0;
    end else if (state == IDLE) begin
      if (found && grant_ok) begin
        state <= BUSY;
        owner <= pick;
        beat <= '0;
      end
    end else if (xfer) begin
      if (beat == BW'(BURST - 1)) begin
        state <= IDLE;
        last_owner <= owner;
        beat <= '0;
      end else
        beat <= beat + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_out_arb.sv
// tb_fifo_out_arb: directed and randomized checks of fifo_out_arb against a FIFO occupancy model
module tb_fifo_out_arb;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] in_TDATA;
  logic [3:0] in_TVALID, in_TREADY, hsv;
  logic [7:0] data_in;
  logic wr_en, busy, rd;
  logic [3:0] capacity, cnt, cnt_init;
  logic [1:0] grant_id;
  logic [11:0] pw, pb;
  logic [7:0] pk [4];
  int tests = 0, fails = 0, w, o, words, hs, cyc;
  int k [4];
  bit act;
  fifo_out_arb dut (
    .clk(clk), .reset(reset), .in_TDATA(in_TDATA), .in_TVALID(in_TVALID),
    .in_TREADY(in_TREADY), .data_in(data_in), .wr_en(wr_en),
    .capacity(capacity), .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    cnt <= reset ? cnt_init : cnt + 4'(wr_en) - 4'(rd && cnt != 0);
  assign capacity = 4'(DEPTH) - cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic ew, input logic eb, input logic [1:0] eg,
                      input logic [3:0] er, input logic [7:0] ed);
    #1;
    chk({tag, "_wr"}, wr_en, ew);
    chk({tag, "_busy"}, busy, eb);
    chk({tag, "_gid"}, grant_id, eg);
    chk({tag, "_rdy"}, in_TREADY, er);
    chk({tag, "_data"}, data_in, ed);
    tick;
  endtask
  initial begin
    reset = 1'b1; in_TVALID = '0; in_TDATA = '0; rd = 1'b0; cnt_init = '0;
    tick; tick;
    chk("rst_rdy", in_TREADY, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_data", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    reset = 1'b0;
    in_TVALID = 4'b0001;
    pw = 12'b0011_1101_1110;
    pb = 12'b1011_1101_1110;
    w = 0;
    for (int i = 0; i < 12; i++) begin
      in_TDATA[7:0] = 8'(w);
      #1;
      chk("A_wr", wr_en, pw[i]);
      chk("A_busy", busy, pb[i]);
      if (pw[i]) begin
        chk("A_data", data_in, w);
        w++;
      end
      if (i == 11) chk("A_full_rdy", in_TREADY, 0);
      tick;
    end
    reset = 1'b1; in_TVALID = '0;
    tick;
    reset = 1'b0; rd = 1'b1; in_TVALID = 4'hF;
    for (int i = 0; i < 4; i++) k[i] = 0;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 4; i++) in_TDATA[i*8 +: 8] = 8'(16 * i + k[i]);
      #1;
      o = (c / 5) % 4;
      act = (c % 5) != 0;
      chk("B_wr", wr_en, act);
      if (act) begin
        chk("B_gid", grant_id, o);
        chk("B_rdy", in_TREADY, 1 << o);
        chk("B_data", data_in, 16 * o + k[o]);
        k[o]++;
      end
      tick;
    end
    in_TDATA = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    in_TVALID = 4'b1101;
    step("C0", 0, 0, 0, 4'b0000, 0);
    step("C1", 1, 1, 2, 4'b0100, 8'hC2);
    step("C2", 1, 1, 2, 4'b0100, 8'hC2);
    in_TVALID = 4'b1001;
    step("C3", 0, 1, 2, 4'b0100, 0);
    step("C4", 0, 1, 2, 4'b0100, 0);
    step("C5", 0, 1, 2, 4'b0100, 0);
    in_TVALID = 4'b1101;
    step("C6", 1, 1, 2, 4'b0100, 8'hC2);
    step("C7", 1, 1, 2, 4'b0100, 8'hC2);
    step("C8", 0, 0, 2, 4'b0000, 0);
    step("C9", 1, 1, 3, 4'b1000, 8'hC3);
    reset = 1'b1;
    step("R0", 1, 1, 3, 4'b1000, 8'hC3);
    reset = 1'b0;
    step("R1", 0, 0, 0, 4'b0000, 0);
    step("R2", 1, 1, 0, 4'b0001, 8'hC0);
    in_TVALID = '0; rd = 1'b0; cnt_init = 4'd6; reset = 1'b1;
    tick;
    reset = 1'b0;
    in_TVALID = 4'b0010;
    in_TDATA = {8'h00, 8'h00, 8'hD1, 8'h00};
`ifdef FIFO_ARB_CAP_RESERVE_EN
    step("D0", 0, 0, 0, 4'b0000, 0);
    step("D1", 0, 0, 0, 4'b0000, 0);
    step("D2", 0, 0, 0, 4'b0000, 0);
    step("D3", 0, 0, 0, 4'b0000, 0);
    rd = 1'b1;
    step("D4", 0, 0, 0, 4'b0000, 0);
    step("D5", 0, 0, 0, 4'b0000, 0);
    step("D6", 0, 0, 0, 4'b0000, 0);
    step("D7", 1, 1, 1, 4'b0010, 8'hD1);
`else
    step("D0", 0, 0, 0, 4'b0000, 0);
    step("D1", 1, 1, 1, 4'b0010, 8'hD1);
    step("D2", 1, 1, 1, 4'b0010, 8'hD1);
    step("D3", 0, 1, 1, 4'b0000, 0);
    rd = 1'b1;
    step("D4", 0, 1, 1, 4'b0000, 0);
    step("D5", 1, 1, 1, 4'b0010, 8'hD1);
    step("D6", 1, 1, 1, 4'b0010, 8'hD1);
    step("D7", 0, 0, 1, 4'b0000, 0);
`endif
    in_TVALID = '0; cnt_init = '0; reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pk[i] = {2'(i), 6'd0};
    words = 0; hs = 0; cyc = 0;
    while (words < 10000 && cyc < 45000) begin
      in_TVALID = 4'($urandom | $urandom | $urandom);
      rd = $urandom_range(0, 7) != 0;
      for (int i = 0; i < 4; i++) in_TDATA[i*8 +: 8] = pk[i];
      #1;
      chk("X_onehot", 32'($onehot0(in_TREADY)), 1);
      if (wr_en) begin
        chk("X_cap", 32'(capacity != 0), 1);
        chk("X_data", data_in, pk[grant_id]);
        words++;
      end
      hsv = in_TVALID & in_TREADY;
      for (int i = 0; i < 4; i++)
        if (hsv[i]) begin
          hs++;
          pk[i] = {2'(i), pk[i][5:0] + 6'd1};
        end
      tick;
      cyc++;
    end
    chk("X_words", words, 10000);
    chk("X_handshakes", hs, words);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
